prio_enc_queue: RTL and testbench
=================================

Name: prio_enc_queue

Overview:
- Parametrised, sequential successor to the 4:2 combinational encoder.
- Captures one-cycle request pulses on N lines into a sticky pending register.
- Presents one pending request at a time as a binary index with a valid/ready handshake, clearing each request as it is accepted.
- Sits between interrupt/event sources and a single consumer; supports fixed-priority or round-robin selection.

Parameters:
- N, 8: number of request lines; legal range 2..256, need not be a power of two.
- RR_MODE, 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- W, $clog2(N): index width; derived localparam, not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request pulses; bit i high for a cycle sets pending[i].
- out_valid  out  1  at least one request is pending.
- out_idx  out  W  encoded index of the selected pending request.
- out_ready  in  1  consumer accepts out_idx this cycle when out_valid is high.
- pending  out  N  pending register, exposed for debug/status.
- count  out  W+1  population count of pending, range 0..N.
- dup  out  1  sticky flag: a request arrived on a line that was already pending.

Behaviour:
- Reset (asynchronous, active-high): pending=0, rr_ptr=0, dup=0. Outputs then read out_valid=0, out_idx=0, count=0. Reset asserted mid-operation discards all pending requests immediately.
- State: pending[N-1:0], rr_ptr[W-1:0] (used only when RR_MODE=1), dup. No other flops.
- out_valid, out_idx and count are combinational from the registered state only; there is no combinational path from req or out_ready to any output.
- Latency: req[i] sampled at edge t makes out_valid observable in the cycle after edge t (one-cycle latency).
- Accept: accept = out_valid & out_ready. clr = one-hot(out_idx) when accept is high, else 0.
- Next pending: pending <= (pending & ~clr) | req.
  - If req[k] and clr[k] occur in the same cycle, bit k stays set; the new request is a fresh event and is not lost.
- Fixed mode (RR_MODE=0): out_idx = highest set index of pending.
- Round-robin mode (RR_MODE=1):
  - out_idx = first set index found scanning rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
  - On accept, rr_ptr <= out_idx+1, wrapping to 0 when out_idx=N-1, including non-power-of-two N.
  - rr_ptr does not change without an accept.
- No pending request: out_valid=0 and out_idx=0. out_ready is ignored while out_valid=0; no state changes in that case.
- Stability: out_valid/out_idx may change without an accept only by gaining higher-priority requests (fixed mode) or nearer requests (RR mode). The consumer must sample out_idx in the cycle it asserts out_ready.
- dup: set on any edge where req[i] & pending[i] & ~clr[i] for some i. Sticky until reset; the duplicate request is merged (no counting).
- count: popcount(pending), width W+1, so count=N is representable.
- Back-to-back: with out_ready held high, one request is retired per cycle. N requests pulsed together drain in exactly N cycles.

Test Plan:
- Reset: assert rst mid-run with pending=8'hA5 -> pending=0, out_valid=0, out_idx=0, count=0, dup=0 without waiting for a clock edge.
- Fixed priority (N=8, RR_MODE=0): pulse req=8'b0010_0110, out_ready=1 -> out_idx sequence 5,2,1 on consecutive cycles, then out_valid=0; count goes 3,2,1,0.
- Round-robin (N=8, RR_MODE=1): hold req=8'hFF every cycle, out_ready=1 -> out_idx 0,1,2,...,7,0 continuously; dup=1 after the second cycle.
- Hold-off: pulse req[3], out_ready=0 for 5 cycles -> out_valid=1 and out_idx=3 steady; raise out_ready -> bit 3 clears the next cycle; no dup.
- Simultaneous set/clear: with pending[4]=1 and out_idx=4 accepted, pulse req[4] in the same cycle -> pending[4] remains 1, out_valid stays 1, dup stays 0.
- Non-power-of-two (N=5, RR_MODE=1): pulse req=5'b10001 with out_ready=1 -> out_idx 0 then 4, then rr_ptr wraps to 0; a later req[0] is served at index 0.

Source files
------------

// File: rtl/prio_enc_queue.sv
// Sticky request capture with a valid/ready index output; fixed-priority
// (highest index) or round-robin selection of the pending requests.
module prio_enc_queue #(
  parameter int N       = 8,
  parameter bit RR_MODE = 1'b0,
  localparam int W      = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic [W:0]   count,
  output logic         dup
);

  logic [N-1:0] r_pending;
  logic [W-1:0] r_rr_ptr;
  logic         r_dup;

  logic         w_found;
  logic         w_hi_found;
  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_lo_idx;
  logic [W-1:0] w_idx;
  logic         w_accept;
  logic [N-1:0] w_clr;
  logic [W-1:0] w_ptr_nxt;
  logic [W:0]   w_count;

  // Round-robin: lowest pending index at or above the pointer, otherwise
  // wrap around to the lowest pending index overall.
  always_comb begin
    w_found    = |r_pending;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_idx      = '0;
    if (RR_MODE) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (r_pending[i]) begin
          w_lo_idx = W'(i);
          if (W'(i) >= r_rr_ptr) begin
            w_hi_found = 1'b1;
            w_hi_idx   = W'(i);
          end
        end
      end
      w_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r_pending[i]) begin
          w_idx = W'(i);
        end
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < N; i++) begin
      w_count = w_count + {{W{1'b0}}, r_pending[i]};
    end
  end

  assign w_accept  = w_found & out_ready;
  assign w_clr     = w_accept ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign w_ptr_nxt = (w_idx == W'(N - 1)) ? '0 : w_idx + 1'b1;

  // A request landing on the bit being cleared re-arms it as a new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_dup     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | req;
      if (|(req & r_pending & ~w_clr)) begin
        r_dup <= 1'b1;
      end
      if (RR_MODE && w_accept) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign out_valid = w_found;
  assign out_idx   = w_idx;
  assign pending   = r_pending;
  assign count     = w_count;
  assign dup       = r_dup;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Bench for prio_enc_queue: three instances (N=8 fixed, N=8 round-robin,
// N=5 round-robin) against a queue-level reference model, plus literal checks.
module tb_prio_enc_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] req_a, req_b;
  logic [4:0] req_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic       v_a, v_b, v_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic [7:0] pend_a, pend_b;
  logic [4:0] pend_c;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       dup_a, dup_b, dup_c;

  prio_enc_queue #(.N(8), .RR_MODE(1'b0)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .out_valid(v_a), .out_idx(idx_a),
    .out_ready(rdy_a), .pending(pend_a), .count(cnt_a), .dup(dup_a));

  prio_enc_queue #(.N(8), .RR_MODE(1'b1)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .out_valid(v_b), .out_idx(idx_b),
    .out_ready(rdy_b), .pending(pend_b), .count(cnt_b), .dup(dup_b));

  prio_enc_queue #(.N(5), .RR_MODE(1'b1)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .out_valid(v_c), .out_idx(idx_c),
    .out_ready(rdy_c), .pending(pend_c), .count(cnt_c), .dup(dup_c));

  int   n_checks = 0;
  int   n_fail   = 0;
  logic chk_en   = 1'b0;

  // Reference state: set of pending request lines, round-robin start, dup flag.
  logic [255:0] m_pend [3];
  int           m_ptr  [3];
  logic         m_dup  [3];

  function automatic int nn(int d);
    return (d == 2) ? 5 : 8;
  endfunction

  function automatic bit is_rr(int d);
    return d != 0;
  endfunction

  function automatic logic [255:0] req_of(int d);
    logic [255:0] r;
    r = '0;
    case (d)
      0: r[7:0] = req_a;
      1: r[7:0] = req_b;
      default: r[4:0] = req_c;
    endcase
    return r;
  endfunction

  function automatic logic rdy_of(int d);
    case (d)
      0: return rdy_a;
      1: return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  function automatic int v_of(int d);
    case (d)
      0: return int'(v_a);
      1: return int'(v_b);
      default: return int'(v_c);
    endcase
  endfunction

  function automatic int idx_of(int d);
    case (d)
      0: return int'(idx_a);
      1: return int'(idx_b);
      default: return int'(idx_c);
    endcase
  endfunction

  function automatic int cnt_of(int d);
    case (d)
      0: return int'(cnt_a);
      1: return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  function automatic int pend_of(int d);
    case (d)
      0: return int'(pend_a);
      1: return int'(pend_b);
      default: return int'(pend_c);
    endcase
  endfunction

  function automatic int dup_of(int d);
    case (d)
      0: return int'(dup_a);
      1: return int'(dup_b);
      default: return int'(dup_c);
    endcase
  endfunction

  // Which pending line is offered: -1 when nothing is pending.
  function automatic int model_sel(int d);
    int n;
    n = nn(d);
    if (!is_rr(d)) begin
      for (int i = n - 1; i >= 0; i--)
        if (m_pend[d][i]) return i;
    end else begin
      for (int k = 0; k < n; k++)
        if (m_pend[d][(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] actual=%0h expected=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        m_pend[d] <= '0;
        m_ptr[d]  <= 0;
        m_dup[d]  <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        int           s;
        logic [255:0] clr;
        s   = model_sel(d);
        clr = '0;
        if (s >= 0 && rdy_of(d)) begin
          clr[s]   = 1'b1;
          m_ptr[d] <= (s + 1) % nn(d);
        end
        if (|(req_of(d) & m_pend[d] & ~clr)) m_dup[d] <= 1'b1;
        m_pend[d] <= (m_pend[d] & ~clr) | req_of(d);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int d = 0; d < 3; d++) begin
        int s;
        s = model_sel(d);
        chk("valid", d, v_of(d), (s >= 0) ? 1 : 0);
        chk("idx", d, idx_of(d), (s >= 0) ? s : 0);
        chk("count", d, cnt_of(d), $countones(m_pend[d]));
        chk("pending", d, pend_of(d), int'(m_pend[d][7:0]));
        chk("dup", d, dup_of(d), int'(m_dup[d]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", d, v_of(d), 0);
      chk("rst_idx", d, idx_of(d), 0);
      chk("rst_count", d, cnt_of(d), 0);
    end
    step();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Fixed priority drain: 5,2,1 then idle.
    req_a = 8'b0010_0110; rdy_a = 1'b1;
    step();
    req_a = '0;
    @(negedge clk); chk("fx_idx", 0, idx_of(0), 5); chk("fx_cnt", 0, cnt_of(0), 3);
    @(negedge clk); chk("fx_idx", 0, idx_of(0), 2); chk("fx_cnt", 0, cnt_of(0), 2);
    @(negedge clk); chk("fx_idx", 0, idx_of(0), 1); chk("fx_cnt", 0, cnt_of(0), 1);
    @(negedge clk); chk("fx_valid", 0, v_of(0), 0); chk("fx_cnt", 0, cnt_of(0), 0);
    step();
    rdy_a = 1'b0;

    // Hold-off: request waits while the consumer is not ready.
    req_a = 8'h08;
    step();
    req_a = '0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 0, v_of(0), 1);
      chk("hold_idx", 0, idx_of(0), 3);
    end
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    @(negedge clk);
    chk("hold_clr_valid", 0, v_of(0), 0);
    chk("hold_clr_pend", 0, pend_of(0), 0);
    chk("hold_dup", 0, dup_of(0), 0);
    step();

    // Accept and re-request the same line in one cycle.
    req_a = 8'h10;
    step();
    rdy_a = 1'b1;
    step();
    req_a = '0; rdy_a = 1'b0;
    @(negedge clk);
    chk("simul_pend", 0, pend_of(0), 8'h10);
    chk("simul_valid", 0, v_of(0), 1);
    chk("simul_dup", 0, dup_of(0), 0);
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;

    // Round-robin with every line requesting every cycle.
    req_b = 8'hFF; rdy_b = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rr_idx", 1, idx_of(1), k % 8);
      if (k == 0) chk("rr_dup0", 1, dup_of(1), 0);
      if (k == 1) chk("rr_dup1", 1, dup_of(1), 1);
    end
    req_b = '0;
    repeat (10) step();
    rdy_b = 1'b0;

    // Non-power-of-two wrap of the round-robin pointer.
    req_c = 5'b10001; rdy_c = 1'b1;
    step();
    req_c = '0;
    @(negedge clk); chk("np2_idx", 2, idx_of(2), 0); chk("np2_valid", 2, v_of(2), 1);
    @(negedge clk); chk("np2_idx", 2, idx_of(2), 4);
    @(negedge clk); chk("np2_valid", 2, v_of(2), 0);
    req_c = 5'b00011;
    step();
    req_c = '0;
    @(negedge clk); chk("np2_wrap_idx", 2, idx_of(2), 0);
    @(negedge clk); chk("np2_wrap_idx", 2, idx_of(2), 1);
    @(negedge clk); chk("np2_wrap_valid", 2, v_of(2), 0);
    rdy_c = 1'b0;
    step();

    // Asynchronous reset in the middle of a cycle.
    req_a = 8'hA5;
    step();
    req_a = '0;
    #2;
    chk("pre_rst_pend", 0, pend_of(0), 8'hA5);
    rst = 1'b1;
    #1;
    chk("arst_pend", 0, pend_of(0), 0);
    chk("arst_valid", 0, v_of(0), 0);
    chk("arst_idx", 0, idx_of(0), 0);
    chk("arst_count", 0, cnt_of(0), 0);
    chk("arst_dup_a", 0, dup_of(0), 0);
    chk("arst_dup_b", 1, dup_of(1), 0);
    step();
    rst = 1'b0;

    // Randomised traffic, occasional full bursts.
    repeat (600) begin
      req_a = 8'($urandom & $urandom & $urandom);
      req_b = 8'($urandom & $urandom & $urandom);
      req_c = 5'($urandom & $urandom);
      if ($urandom_range(0, 19) == 0) req_a = 8'hFF;
      if ($urandom_range(0, 19) == 0) req_b = 8'hFF;
      if ($urandom_range(0, 19) == 0) req_c = 5'h1F;
      rdy_a = 1'($urandom_range(0, 1));
      rdy_b = 1'($urandom_range(0, 1));
      rdy_c = 1'($urandom_range(0, 1));
      step();
    end
    req_a = '0; req_b = '0; req_c = '0;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    repeat (10) step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
